// File: rtl/uart_frame_loader_pkg.sv
// osg_pkg: frame-loader defaults, FSM state type and the RAM address width
// shared with the channel RAM and the UART receiver.
package osg_pkg;
    localparam int         DEF_FRAME_LEN = 113;
    localparam logic [7:0] DEF_SYNC      = 8'hAA;
    localparam int         RAM_AW        = 8;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
endpackage

// File: rtl/uart_frame_loader_byte_timeout.sv
// byte_timeout: counts idle clocks while a frame is open; expire pulses when
// the gap since the last byte reaches TIMEOUT_CYC clocks, unless a byte arrives.
module byte_timeout #(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] r_timer;
    assign expire = run && !kick && (r_timer == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_timer <= '0;
        else        r_timer <= (!run || kick || expire) ? '0 : r_timer + 1'b1;
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: hunts for SYNC, streams FRAME_LEN payload bytes into RAM
// top-down, and only re-enables RAM updates once the XOR checksum verifies.
module uart_frame_loader
    import osg_pkg::*;
#(
    parameter int         FRAME_LEN   = DEF_FRAME_LEN,
    parameter logic [7:0] SYNC        = DEF_SYNC,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        ram_in,
    output logic [RAM_AW-1:0] ram_w_addr,
    output logic              ram_write,
    output logic              ram_read,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);
    localparam int CW = $clog2(FRAME_LEN);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_csum;
    logic          w_expire;
    logic          w_run;
    logic [7:0]    w_err_next;
    assign w_run      = r_state != IDLE;
    assign w_err_next = err_cnt + {7'd0, ~&err_cnt};
    byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_run),
        .kick   (rx_done),
        .expire (w_expire)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_csum     <= '0;
            ram_in     <= '0;
            ram_w_addr <= '0;
            ram_write  <= 1'b0;
            ram_read   <= 1'b0;
            busy       <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            ram_write <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_done) begin
                case (r_state)
                    IDLE: if (rx_data == SYNC) begin
                        r_state  <= PAYLOAD;
                        r_cnt    <= '0;
                        r_csum   <= '0;
                        ram_read <= 1'b0;
                        busy     <= 1'b1;
                    end
                    PAYLOAD: begin
                        ram_write  <= 1'b1;
                        ram_w_addr <= RAM_AW'(FRAME_LEN - 1) - RAM_AW'(r_cnt);
                        ram_in     <= rx_data;
                        r_csum     <= r_csum ^ rx_data;
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == CW'(FRAME_LEN - 1)) r_state <= CHECK;
                    end
                    CHECK: begin
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                        frame_ok  <= rx_data == r_csum;
                        frame_err <= rx_data != r_csum;
                        ram_read  <= rx_data == r_csum;
                        if (rx_data != r_csum) err_cnt <= w_err_next;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (w_expire) begin
                // ram_read is already 0 here: it dropped on the SYNC byte
                r_state   <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_cnt   <= w_err_next;
            end
        end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: byte-level reference model checked every cycle, plus
// literal expectations on write counts, addresses, latency and error counts.
module tb_uart_frame_loader;
    localparam int TC = 100;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic [7:0] ram_in, ram_w_addr, err_cnt;
    logic       ram_write, ram_read, busy, frame_ok, frame_err;
    int errors = 0, checks = 0;
    int cyc = 0, last_byte = 0, wr_cnt = 0;
    logic [7:0] shadow [0:112];
    int         m_pos = -1, m_idle = 0;
    logic [7:0] m_x = '0;
    logic       e_write = 0, e_read = 0, e_busy = 0, e_ok = 0, e_err = 0;
    logic [7:0] e_addr = '0, e_in = '0, e_cnt = '0;

    uart_frame_loader #(.TIMEOUT_CYC(TC)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .ram_in(ram_in), .ram_w_addr(ram_w_addr), .ram_write(ram_write),
        .ram_read(ram_read), .busy(busy), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: position in frame -1 = hunting, 0..112 payload, 113 checksum
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pos = -1; m_idle = 0; m_x = '0;
            e_write = 0; e_read = 0; e_busy = 0; e_ok = 0; e_err = 0;
            e_addr = '0; e_in = '0; e_cnt = '0;
        end else begin
            cyc++;
            e_write = 0; e_ok = 0; e_err = 0;
            if (rx_done) begin
                last_byte = cyc;
                m_idle = 0;
                if (m_pos < 0) begin
                    if (rx_data == 8'hAA) begin m_pos = 0; m_x = '0; e_read = 0; e_busy = 1; end
                end else if (m_pos < 113) begin
                    e_write = 1; e_addr = 8'(112 - m_pos); e_in = rx_data;
                    m_x = m_x ^ rx_data; m_pos++;
                end else begin
                    e_ok = rx_data == m_x; e_err = !e_ok; e_read = e_ok;
                    if (e_err && e_cnt != 8'hFF) e_cnt++;
                    m_pos = -1; e_busy = 0;
                end
            end else if (m_pos >= 0) begin
                m_idle++;
                if (m_idle == TC) begin
                    e_err = 1; m_pos = -1; e_busy = 0; m_idle = 0;
                    if (e_cnt != 8'hFF) e_cnt++;
                end
            end
        end

    always @(negedge clk)
        if (rst_n) begin
            chk("ram_write", ram_write, e_write);
            chk("ram_w_addr", ram_w_addr, e_addr);
            chk("ram_in", ram_in, e_in);
            chk("ram_read", ram_read, e_read);
            chk("busy", busy, e_busy);
            chk("frame_ok", frame_ok, e_ok);
            chk("frame_err", frame_err, e_err);
            chk("err_cnt", err_cnt, e_cnt);
            if (ram_write) begin wr_cnt++; shadow[ram_w_addr] = ram_in; end
        end

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] last, input logic bad);
        logic [7:0] x;
        x = '0;
        send(8'hAA);
        for (int i = 1; i <= 112; i++) begin send(8'(i)); x ^= 8'(i); end
        send(last); x ^= last;
        send(x ^ {7'd0, bad});
        chk("pulse_ok", frame_ok, !bad);
        chk("pulse_err", frame_err, bad);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs"}, {ram_in, ram_w_addr, ram_write, ram_read, busy, frame_ok, frame_err, err_cnt}, 0);
    endtask

    initial begin
        int w0, lat;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_read", ram_read, 0);

        w0 = wr_cnt;
        send_frame(8'h71, 1'b0);
        @(negedge clk); #1;
        chk("good_writes", wr_cnt - w0, 113);
        chk("good_addr112", shadow[112], 8'h01);
        chk("good_addr0", shadow[0], 8'h71);
        chk("good_read", ram_read, 1);
        chk("good_errcnt", err_cnt, 0);

        w0 = wr_cnt;
        send_frame(8'h71, 1'b1);
        @(negedge clk); #1;
        chk("bad_writes", wr_cnt - w0, 113);
        chk("bad_errcnt", err_cnt, 1);
        chk("bad_read", ram_read, 0);

        w0 = wr_cnt;
        send(8'hAA);
        for (int i = 1; i <= 50; i++) send(8'(i));
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (frame_err) begin lat = cyc - last_byte; break; end
        end
        chk("to_latency", lat, 100);
        chk("to_errcnt", err_cnt, 2);
        repeat (20) @(negedge clk);
        chk("to_writes", wr_cnt - w0, 50);
        chk("to_busy", busy, 0);
        send_frame(8'h71, 1'b0);
        @(negedge clk); #1;
        chk("to_recover_read", ram_read, 1);

        w0 = wr_cnt;
        send(8'h55); send(8'h00);
        repeat (3) @(negedge clk); #1;
        chk("noise_writes", wr_cnt - w0, 0);
        chk("noise_busy", busy, 0);
        send_frame(8'h71, 1'b0);
        @(negedge clk); #1;
        chk("noise_frame_writes", wr_cnt - w0, 113);

        send(8'hAA);
        for (int i = 1; i <= 30; i++) send(8'(i));
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        send_frame(8'h71, 1'b0);
        @(negedge clk); #1;
        chk("mr_writes", wr_cnt - w0, 113);
        chk("mr_read", ram_read, 1);
        chk("mr_errcnt", err_cnt, 0);

        send_frame(8'hFF, 1'b0);
        @(negedge clk); #1;
        chk("start_addr0", shadow[0], 8'hFF);
        chk("start_read", ram_read, 1);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
